// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin merge of byte-wide TX sources into the MAC stream
// A granted source that stalls mid-frame past TIMEOUT gets its frame cut short as bad and its tail flushed.
module eth_tx_frame_arbiter #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               tx_clk,
  input  logic               tx_rst,
  input  logic [PORTS*8-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]   s_axis_tvalid,
  output logic [PORTS-1:0]   s_axis_tready,
  input  logic [PORTS-1:0]   s_axis_tlast,
  input  logic [PORTS-1:0]   s_axis_tuser,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  input  logic               cfg_enable,
  output logic [PORTS-1:0]   status_grant,
  output logic               status_abort
);

  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             abort_q, abort_d;

  logic             out_free;
  logic             sel_valid, sel_last, sel_user;
  logic [7:0]       sel_data;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] scan_idx;
  logic             found;

  assign out_free  = m_axis_tready || !tvalid_q;
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_user  = s_axis_tuser[grant_q];
  assign sel_data  = s_axis_tdata[{grant_q, 3'b000} +: 8];
  assign next_ptr  = (grant_q == LAST_PORT) ? '0 : grant_q + PTR_W'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    stall_d       = stall_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    abort_d       = 1'b0;
    s_axis_tready = '0;
    scan_idx      = '0;
    found         = 1'b0;

    if (out_free) tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          // First requester at or after rr_ptr, wrapping past the top port.
          for (int k = 0; k < PORTS; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % PORTS);
            if (!found && s_axis_tvalid[scan_idx]) begin
              found   = 1'b1;
              grant_d = scan_idx;
            end
          end
          if (found) begin
            state_d = ST_XFER;
            stall_d = '0;
          end
        end
      end
      ST_XFER: begin
        s_axis_tready[grant_q] = out_free;
        if (sel_valid && out_free) begin
          tdata_d  = sel_data;
          tvalid_d = 1'b1;
          tlast_d  = sel_last;
          tuser_d  = sel_user;
          stall_d  = '0;
          if (sel_last) begin
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end
        end else if (!sel_valid) begin
          if ((TIMEOUT != 0) && (stall_q == CNT_MAX) && out_free) begin
            tdata_d  = 8'h00;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
            abort_d  = 1'b1;
            stall_d  = '0;
            state_d  = ST_FLUSH;
          end else if (stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        s_axis_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      stall_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      stall_q  <= stall_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      abort_q  <= abort_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign status_abort  = abort_q;
  assign status_grant  = (state_q == ST_IDLE) ? '0 : (PORTS'(1) << grant_q);

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - self-checking bench for eth_tx_frame_arbiter
`timescale 1ns/1ps
module tb_eth_tx_frame_arbiter;

  localparam int PORTS   = 2;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [7:0] gap;
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic               tx_clk = 1'b0;
  logic               tx_rst;
  logic [PORTS*8-1:0] s_axis_tdata;
  logic [PORTS-1:0]   s_axis_tvalid;
  logic [PORTS-1:0]   s_axis_tready;
  logic [PORTS-1:0]   s_axis_tlast;
  logic [PORTS-1:0]   s_axis_tuser;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic               m_axis_tuser;
  logic               cfg_enable;
  logic [PORTS-1:0]   status_grant;
  logic               status_abort;

  eth_tx_frame_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_enable    (cfg_enable),
    .status_grant  (status_grant),
    .status_abort  (status_abort)
  );

  always #5 tx_clk = ~tx_clk;

  int          checks = 0;
  int          failures = 0;
  beat_t       srcq[PORTS][$];
  logic [9:0]  outq[$];
  logic [9:0]  expq[$];
  int          abort_cnt = 0;
  int          gviol = 0;
  int          bpviol = 0;
  int          mready_mode = 0;
  logic        tog = 1'b0;

  // Source/sink models: drive on the falling edge, observe handshakes just before the rising edge.
  always @(negedge tx_clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (srcq[p].size() > 0 && srcq[p][0].gap != 8'd0) begin
        s_axis_tvalid[p] = 1'b0;
        srcq[p][0].gap = srcq[p][0].gap - 8'd1;
      end else if (srcq[p].size() > 0) begin
        s_axis_tvalid[p]         = 1'b1;
        s_axis_tdata[p*8 +: 8]   = srcq[p][0].data;
        s_axis_tlast[p]          = srcq[p][0].last;
        s_axis_tuser[p]          = srcq[p][0].user;
      end else begin
        s_axis_tvalid[p] = 1'b0;
      end
    end
    if (mready_mode == 0) begin
      m_axis_tready = 1'b1;
      tog = 1'b0;
    end else if (mready_mode == 1) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tog = 1'b0;
    end else begin
      tog = ~tog;
      m_axis_tready = tog;
    end
    #4;
    if (!tx_rst) begin
      for (int p = 0; p < PORTS; p++) begin
        if (s_axis_tvalid[p] && s_axis_tready[p]) begin
          logic [PORTS-1:0] oh;
          oh = '0;
          oh[p] = 1'b1;
          if (status_grant !== oh) gviol++;
          if (srcq[p].size() > 0) void'(srcq[p].pop_front());
        end
      end
      if ($countones(s_axis_tready) > 1) gviol++;
      if (m_axis_tvalid && !m_axis_tready && s_axis_tready != '0) bpviol++;
      if (m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (status_abort) abort_cnt++;
    end
  end

  task automatic push_frame(input int p, input int len, input int gap_max, input bit seq, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? base + 8'(i) : 8'($urandom);
      b.last = (i == len - 1);
      b.user = 1'b0;
      b.gap  = (i == 0) ? 8'd0 : 8'($urandom_range(0, gap_max));
      srcq[p].push_back(b);
      expq.push_back({1'b0, b.last, b.data});
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < PORTS; p++) srcq[p].delete();
    outq.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    tx_rst = 1'b1;
    clear_all();
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    tx_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((srcq[0].size() != 0 || srcq[1].size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge tx_clk);
      n++;
    end
    repeat (3) @(posedge tx_clk);
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_drain: cycles=%0d required below 3000", name, n);
    end
  endtask

  task automatic compare_out(input string name);
    int nprint = 0;
    int m;
    checks++;
    if (outq.size() != expq.size()) begin
      failures++;
      $display("FAIL %s_len: got %0d beats, required %0d", name, outq.size(), expq.size());
    end
    m = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (outq[i] !== expq[i]) begin
        failures++;
        if (nprint < 8) $display("FAIL %s_beat%0d: got user/last/data=%h, required %h", name, i, outq[i], expq[i]);
        nprint++;
      end
    end
    outq.delete();
    expq.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready, status_grant, status_abort} !== '0) begin
      failures++;
      $display("FAIL %s: tdata=%h tvalid=%b tlast=%b tuser=%b s_tready=%b grant=%b abort=%b, required all 0",
               name, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready, status_grant, status_abort);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    tx_rst = 1'b1;
    #1;
    check_outputs_zero("reset_state");
    do_reset();
    #1;
    check_outputs_zero("after_release_idle");
  endtask

  task automatic test_single_frame();
    mready_mode = 0;
    gviol = 0;
    push_frame(0, 64, 0, 1'b1, 8'h00);
    drain("single");
    compare_out("single");
    check_int("single_grant_viol", gviol, 0);
    check_int("single_grant_after", int'(status_grant), 0);
  endtask

  task automatic test_fairness();
    do_reset();
    mready_mode = 0;
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < PORTS; p++)
        push_frame(p, 8, 0, 1'b1, 8'(p * 128 + i * 16));
    drain("fair");
    compare_out("fair");
  endtask

  task automatic test_backpressure();
    mready_mode = 2;
    bpviol = 0;
    push_frame(1, 10, 0, 1'b1, 8'hA0);
    drain("bp");
    compare_out("bp");
    check_int("bp_ready_while_held", bpviol, 0);
    mready_mode = 0;
  endtask

  task automatic test_random();
    do_reset();
    mready_mode = 1;
    abort_cnt = 0;
    gviol = 0;
    for (int i = 0; i < 6; i++)
      for (int p = 0; p < PORTS; p++)
        push_frame(p, $urandom_range(1, 12), TIMEOUT - 1, 1'b0, 8'h00);
    drain("rand");
    compare_out("rand");
    check_int("rand_no_abort", abort_cnt, 0);
    check_int("rand_grant_viol", gviol, 0);
    mready_mode = 0;
  endtask

  task automatic test_timeout();
    beat_t b;
    do_reset();
    mready_mode = 0;
    abort_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      b.data = 8'h10 + 8'(i);
      b.last = (i == 7);
      b.user = 1'b0;
      b.gap  = (i == 5) ? 8'd10 : 8'd0;
      srcq[0].push_back(b);
      if (i < 5) expq.push_back({2'b00, b.data});
    end
    expq.push_back({2'b11, 8'h00});
    drain("timeout");
    compare_out("timeout");
    check_int("timeout_abort_pulses", abort_cnt, 1);
    check_int("timeout_grant_idle", int'(status_grant), 0);
    push_frame(1, 4, 0, 1'b1, 8'hC0);
    push_frame(0, 4, 0, 1'b1, 8'hD0);
    drain("after_flush");
    compare_out("after_flush");
  endtask

  task automatic test_enable_gating();
    int viol = 0;
    do_reset();
    cfg_enable = 1'b0;
    push_frame(0, 5, 0, 1'b1, 8'h30);
    push_frame(1, 5, 0, 1'b1, 8'h40);
    repeat (20) begin
      @(posedge tx_clk);
      #1;
      if (s_axis_tready != '0 || status_grant != '0 || m_axis_tvalid) viol++;
    end
    check_int("gate_no_activity", viol, 0);
    check_int("gate_no_output", outq.size(), 0);
    cfg_enable = 1'b1;
    drain("gate");
    compare_out("gate");
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    push_frame(0, 3, 0, 1'b1, 8'h50);
    drain("pre_rst");
    compare_out("pre_rst");
    push_frame(1, 30, 0, 1'b1, 8'h60);
    while (outq.size() < 5 && n < 500) begin
      @(posedge tx_clk);
      n++;
    end
    check_int("midframe_reached", (n < 500) ? 1 : 0, 1);
    #3;
    tx_rst = 1'b1;
    #1;
    check_outputs_zero("reset_midframe");
    clear_all();
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk);
    tx_rst = 1'b0;
    push_frame(1, 4, 0, 1'b1, 8'h90);
    push_frame(0, 4, 0, 1'b1, 8'h80);
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back({1'b0, i == 3, 8'h80 + 8'(i)});
    for (int i = 0; i < 4; i++) expq.push_back({1'b0, i == 3, 8'h90 + 8'(i)});
    drain("post_rst");
    compare_out("post_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tx_rst        = 1'b1;
    cfg_enable    = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    test_reset();
    test_single_frame();
    test_fairness();
    test_backpressure();
    test_random();
    test_timeout();
    test_enable_gating();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
